// File: rtl/msrv32_irq_arbiter_if.sv
// msrv32_irq_arbiter_if
//   Claim/complete handshake between the trap handler CSR path and the
//   external interrupt arbiter.
//   master : drives claim_req_in, complete_req_in, complete_id_in
//   slave  : drives claim_valid_out, claim_id_out, complete_err_out
interface msrv32_irq_arbiter_if #(
    parameter int unsigned IDW = 4
);
    logic           claim_req_in;
    logic           complete_req_in;
    logic [IDW-1:0] complete_id_in;
    logic           claim_valid_out;
    logic [IDW-1:0] claim_id_out;
    logic           complete_err_out;

    modport master (
        output claim_req_in, complete_req_in, complete_id_in,
        input  claim_valid_out, claim_id_out, complete_err_out
    );

    modport slave (
        input  claim_req_in, complete_req_in, complete_id_in,
        output claim_valid_out, claim_id_out, complete_err_out
    );
endinterface

// File: rtl/msrv32_irq_arbiter.sv
// msrv32_irq_arbiter
//   Platform-level external interrupt arbiter for the msrv32 core.
//   Synchronises NUM_SRC device lines, latches them as pending (edge or
//   level per source), picks the lowest-numbered eligible source (ID 1 is
//   highest priority) and runs a claim/complete handshake so each source
//   has at most one interrupt in service.
//   Ports:
//     clk_in          core clock, rising edge
//     reset_n_in      asynchronous active-low reset
//     irq_src_in      raw asynchronous device interrupt lines
//     src_enable_in   per-source enable
//     edge_mode_in    1 = rising-edge triggered, 0 = level triggered
//     bus             claim/complete handshake (slave side)
//     e_irq_out       external interrupt request to machine control
//     in_service_out  per-source in-service flags
module msrv32_irq_arbiter #(
    parameter int unsigned NUM_SRC     = 8,
    parameter int unsigned IDW         = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_in,
    input  logic                 reset_n_in,
    input  logic [NUM_SRC-1:0]   irq_src_in,
    input  logic [NUM_SRC-1:0]   src_enable_in,
    input  logic [NUM_SRC-1:0]   edge_mode_in,
    msrv32_irq_arbiter_if.slave  bus,
    output logic                 e_irq_out,
    output logic [NUM_SRC-1:0]   in_service_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_SERVICE
    } state_t;

    logic [NUM_SRC-1:0] r_sync [SYNC_STAGES];
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_in_service;
    logic [IDW-1:0]     r_best_id_q;
    logic [IDW-1:0]     r_claim_id_q;
    state_t             r_state;
    logic               r_e_irq;
    logic               r_claim_valid;
    logic [IDW-1:0]     r_claim_id;
    logic               r_complete_err;

    logic [NUM_SRC-1:0] w_sync;
    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_eligible;
    logic [NUM_SRC-1:0] w_claim_mask;
    logic [NUM_SRC-1:0] w_done_mask;
    logic [IDW-1:0]     w_best_id;
    logic               w_claim_take;
    logic               w_complete_ok;

    assign w_sync = r_sync[SYNC_STAGES-1];

    always_comb begin
        w_rise     = w_sync & ~r_prev;
        w_eligible = r_pending & src_enable_in & ~r_in_service;

        // First hit wins, so the lowest index (highest priority) is kept.
        w_best_id = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (w_eligible[i] && (w_best_id == '0)) begin
                w_best_id = IDW'(i + 1);
            end
        end

        // A claim that coincides with withdrawal (best == 0) is not taken.
        w_claim_take  = bus.claim_req_in && (r_state == ST_REQ) &&
                        (r_best_id_q != '0);
        w_complete_ok = bus.complete_req_in && (r_state == ST_SERVICE) &&
                        (bus.complete_id_in == r_claim_id_q);

        w_claim_mask = '0;
        w_done_mask  = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_claim_mask[i] = w_claim_take  && (r_best_id_q  == IDW'(i + 1));
            w_done_mask[i]  = w_complete_ok && (r_claim_id_q == IDW'(i + 1));
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            for (int unsigned s = 0; s < SYNC_STAGES; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= irq_src_in;
            for (int unsigned s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_prev       <= '0;
            r_pending    <= '0;
            r_in_service <= '0;
            r_best_id_q  <= '0;
        end else begin
            r_prev <= w_sync;
            // Edge sources: a new edge wins over a same-cycle claim clear.
            // Level sources simply follow the synchronised line.
            r_pending <= (edge_mode_in & ((r_pending & ~w_claim_mask) | w_rise)) |
                         (~edge_mode_in & w_sync);
            r_in_service <= (r_in_service | w_claim_mask) & ~w_done_mask;
            r_best_id_q  <= w_best_id;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state        <= ST_IDLE;
            r_e_irq        <= 1'b0;
            r_claim_valid  <= 1'b0;
            r_claim_id     <= '0;
            r_claim_id_q   <= '0;
            r_complete_err <= 1'b0;
        end else begin
            r_claim_valid  <= bus.claim_req_in;
            r_complete_err <= bus.complete_req_in && !w_complete_ok;
            if (bus.claim_req_in) begin
                r_claim_id <= w_claim_take ? r_best_id_q : '0;
            end

            // e_irq_out tracks the state being entered, not the one left.
            case (r_state)
                ST_IDLE: begin
                    if (r_best_id_q != '0) begin
                        r_state <= ST_REQ;
                        r_e_irq <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_claim_take) begin
                        r_state      <= ST_SERVICE;
                        r_e_irq      <= 1'b0;
                        r_claim_id_q <= r_best_id_q;
                    end else if (r_best_id_q == '0) begin
                        r_state <= ST_IDLE;
                        r_e_irq <= 1'b0;
                    end
                end
                ST_SERVICE: begin
                    if (w_complete_ok) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_e_irq <= 1'b0;
                end
            endcase
        end
    end

    assign e_irq_out            = r_e_irq;
    assign in_service_out       = r_in_service;
    assign bus.claim_valid_out  = r_claim_valid;
    assign bus.claim_id_out     = r_claim_id;
    assign bus.complete_err_out = r_complete_err;

endmodule

// File: tb/tb_msrv32_irq_arbiter.sv
module tb_msrv32_irq_arbiter;

    localparam int NSRC = 8;
    localparam int SYNC = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] irq_src;
    logic [7:0] en;
    logic [7:0] edge_m;
    logic       e_irq;
    logic [7:0] ins;

    int checks = 0;
    int errors = 0;

    msrv32_irq_arbiter_if #(.IDW(4)) bus ();

    msrv32_irq_arbiter #(
        .NUM_SRC    (8),
        .IDW        (4),
        .SYNC_STAGES(2)
    ) dut (
        .clk_in        (clk),
        .reset_n_in    (rst_n),
        .irq_src_in    (irq_src),
        .src_enable_in (en),
        .edge_mode_in  (edge_m),
        .bus           (bus.slave),
        .e_irq_out     (e_irq),
        .in_service_out(ins)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // The pipeline is kept as a delay line of input snapshots; the request
    // side is described by "raised" (core is being asked) and "outstanding"
    // (ID currently claimed, 0 if none).
    bit [7:0] m_pipe [SYNC];
    bit [7:0] m_prev, m_pend, m_ins;
    int       m_best, m_out, m_cid;
    bit       m_raised, m_cv, m_cerr;

    task automatic m_reset();
        for (int s = 0; s < SYNC; s++) m_pipe[s] = '0;
        m_prev = '0; m_pend = '0; m_ins = '0;
        m_best = 0; m_out = 0; m_cid = 0;
        m_raised = 0; m_cv = 0; m_cerr = 0;
    endtask

    task automatic model_step();
        bit [7:0] s_now, rise, elig;
        int claimed, nbest, old_out;
        bit ok;
        s_now = m_pipe[SYNC-1];
        rise  = s_now & ~m_prev;
        claimed = 0;
        if (bus.claim_req_in && m_raised && m_best != 0) claimed = m_best;
        m_cv = bus.claim_req_in;
        if (bus.claim_req_in) m_cid = claimed;
        ok = bus.complete_req_in && (m_out != 0) && (int'(bus.complete_id_in) == m_out);
        m_cerr = bus.complete_req_in && !ok;
        elig = m_pend & en & ~m_ins;
        nbest = 0;
        for (int i = NSRC - 1; i >= 0; i--) if (elig[i]) nbest = i + 1;
        old_out = m_out;
        if (claimed != 0) begin
            m_out = claimed; m_raised = 0;
        end else if (ok) begin
            m_out = 0;
        end else if (m_raised && m_best == 0) begin
            m_raised = 0;
        end else if (!m_raised && m_out == 0 && m_best != 0) begin
            m_raised = 1;
        end
        for (int i = 0; i < NSRC; i++) begin
            if (edge_m[i]) m_pend[i] = rise[i] | (m_pend[i] & (claimed != i + 1));
            else           m_pend[i] = s_now[i];
        end
        if (claimed != 0) m_ins[claimed-1] = 1'b1;
        if (ok)           m_ins[old_out-1] = 1'b0;
        m_best = nbest;
        for (int s = SYNC - 1; s > 0; s--) m_pipe[s] = m_pipe[s-1];
        m_pipe[0] = irq_src;
        m_prev = s_now;
    endtask

    // ---------------- checking helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        check("m_e_irq", 32'(e_irq), 32'(m_raised));
        check("m_claim_valid", 32'(bus.claim_valid_out), 32'(m_cv));
        check("m_claim_id", 32'(bus.claim_id_out), 32'(m_cid));
        check("m_in_service", 32'(ins), 32'(m_ins));
        check("m_complete_err", 32'(bus.complete_err_out), 32'(m_cerr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_claim(input string tag, input int exp_id);
        bus.claim_req_in = 1'b1;
        tick();
        bus.claim_req_in = 1'b0;
        check(tag, 32'(bus.claim_id_out), 32'(exp_id));
    endtask

    task automatic do_complete(input int id);
        bus.complete_req_in = 1'b1;
        bus.complete_id_in  = 4'(id);
        tick();
        bus.complete_req_in = 1'b0;
        bus.complete_id_in  = '0;
    endtask

    task automatic wait_irq(input string tag);
        for (int n = 0; n < 40 && e_irq !== 1'b1; n++) tick();
        check(tag, 32'(e_irq), 32'd1);
    endtask

    task automatic outputs_zero(input string tag);
        check({tag, "_e_irq"}, 32'(e_irq), 32'd0);
        check({tag, "_cv"}, 32'(bus.claim_valid_out), 32'd0);
        check({tag, "_cid"}, 32'(bus.claim_id_out), 32'd0);
        check({tag, "_ins"}, 32'(ins), 32'd0);
        check({tag, "_cerr"}, 32'(bus.complete_err_out), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit saw_high;
        rst_n = 1'b0;
        irq_src = '0; en = 8'hFF; edge_m = 8'hFF;
        bus.claim_req_in = 1'b0; bus.complete_req_in = 1'b0; bus.complete_id_in = '0;
        m_reset();
        #23;
        outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        ticks(2);

        // Edge source 2 (ID 3): one-cycle pulse, request after 5 edges.
        irq_src = 8'h04;
        tick();
        irq_src = 8'h00;
        ticks(3);
        check("lat_before5", 32'(e_irq), 32'd0);
        tick();
        check("lat_at5", 32'(e_irq), 32'd1);
        do_claim("claim_id3", 3);
        check("claim_pulse", 32'(bus.claim_valid_out), 32'd1);
        check("claim_drops_irq", 32'(e_irq), 32'd0);
        check("ins_after_claim", 32'(ins), 32'h04);
        tick();
        check("claim_pulse_one", 32'(bus.claim_valid_out), 32'd0);

        // Wrong-ID complete is rejected, right one retires the source.
        do_complete(5);
        check("bad_complete_err", 32'(bus.complete_err_out), 32'd1);
        check("bad_complete_ins", 32'(ins), 32'h04);
        do_complete(3);
        check("good_complete_ins", 32'(ins), 32'h00);
        check("good_complete_err", 32'(bus.complete_err_out), 32'd0);
        ticks(4);
        check("idle_after_complete", 32'(e_irq), 32'd0);
        do_complete(0);
        check("complete_idle_err", 32'(bus.complete_err_out), 32'd1);

        // Level sources 5 and 1 held high: priority goes to ID 2 both times.
        edge_m = 8'h00;
        irq_src = 8'h22;
        wait_irq("lvl_irq1");
        do_claim("lvl_claim1", 2);
        do_complete(2);
        wait_irq("lvl_irq2");
        do_claim("lvl_claim2", 2);
        do_complete(2);
        irq_src = 8'h00;
        ticks(12);

        // Level source 3 (ID 4) withdraws before a claim.
        irq_src = 8'h08;
        saw_high = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (e_irq === 1'b1) saw_high = 1;
        end
        irq_src = 8'h00;
        for (int n = 0; n < 20 && e_irq !== 1'b0; n++) tick();
        check("withdraw_seen", 32'(saw_high), 32'd1);
        check("withdraw_low", 32'(e_irq), 32'd0);
        ticks(3);
        do_claim("withdraw_claim0", 0);

        // Edge source 7 (ID 8): second edge while in service is kept pending.
        edge_m = 8'hFF;
        irq_src = 8'h80; tick(); irq_src = 8'h00;
        wait_irq("e8_irq1");
        do_claim("e8_claim1", 8);
        ticks(2);
        irq_src = 8'h80; tick(); irq_src = 8'h00;
        ticks(6);
        check("e8_held_low", 32'(e_irq), 32'd0);
        do_complete(8);
        wait_irq("e8_irq2");
        do_claim("e8_claim2", 8);
        do_complete(8);
        ticks(4);

        // Asynchronous reset in the middle of a service.
        irq_src = 8'h04; tick(); irq_src = 8'h00;
        wait_irq("rst_irq");
        do_claim("rst_claim", 3);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 outputs_zero("midreset");
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ticks(3);
        do_claim("post_reset_claim0", 0);
        ticks(2);

        // Randomised traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 7) == 0) irq_src[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) begin
                edge_m = 8'($urandom);
                en     = 8'($urandom | $urandom);
            end
            bus.claim_req_in    = ($urandom_range(0, 5) == 0);
            bus.complete_req_in = 1'b0;
            bus.complete_id_in  = '0;
            if (m_out != 0 && $urandom_range(0, 3) == 0) begin
                bus.complete_req_in = 1'b1;
                bus.complete_id_in  = 4'(m_out);
            end else if ($urandom_range(0, 39) == 0) begin
                bus.complete_req_in = 1'b1;
                bus.complete_id_in  = 4'($urandom_range(0, 15));
            end
            tick();
        end
        bus.claim_req_in = 1'b0; bus.complete_req_in = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
